// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 64;

  // Most negative two's-complement value at the default width.
  localparam logic [XLEN_DEF-1:0] MIN_VAL = {1'b1, {(XLEN_DEF-1){1'b0}}};

  // funct3 encodings of the M extension.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the register file and the muldiv unit.
import muldiv_pkg::*;

interface muldiv_if #(
  parameter int XLEN = XLEN_DEF
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      dest_in;
  logic            busy;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic [4:0]      dest_reg;
  logic            reg_write;

  // Issuing side: register-file read stage / bench.
  modport master (
    output start, funct3, operand_a, operand_b, dest_in,
    input  busy, result_valid, result, dest_reg, reg_write
  );

  // The unit itself.
  modport slave (
    input  start, funct3, operand_a, operand_b, dest_in,
    output busy, result_valid, result, dest_reg, reg_write
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of either an LSB-first shift-add multiply or an MSB-first
// restoring divide. {hi,lo} is the 2*XLEN working register: for multiply hi is
// the partial product and lo the remaining multiplier; for divide hi is the
// partial remainder and lo the dividend being replaced by quotient bits.
module muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Single shift-add or shift-subtract step; diff[XLEN] set means borrow.
  always_comb begin
    sum    = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    rem_sh = {hi_i, lo_i[XLEN-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    hi_o   = sum[XLEN:1];
    lo_o   = {sum[0], lo_i[XLEN-1:1]};
    if (is_div_i) begin
      if (!diff[XLEN]) begin
        hi_o = diff[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b1};
      end else begin
        hi_o = rem_sh[XLEN-1:0];
        lo_o = {lo_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit. Works on operand magnitudes for XLEN
// cycles, then applies sign correction and the divide corner-case overrides.
// Fixed latency of XLEN+2 edges including the accept edge.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  muldiv_if.slave    bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  muldiv_op_e      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      dest_q, dest_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] step_hi, step_lo;
  logic            is_div_q;

  muldiv_op_e      op_in;
  logic            is_div_in, neg_a_in, neg_b_in;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, fix_res;

  assign is_div_q = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (is_div_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Decode the incoming request: signedness per op and operand magnitudes.
  always_comb begin
    op_in     = muldiv_op_e'(bus.funct3);
    is_div_in = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    neg_a_in  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.operand_a[XLEN-1];
    neg_b_in  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && bus.operand_b[XLEN-1];
    mag_a     = neg_a_in ? (~bus.operand_a + 1'b1) : bus.operand_a;
    mag_b     = neg_b_in ? (~bus.operand_b + 1'b1) : bus.operand_b;
  end

  // Final result: sign-correct the raw product/quotient/remainder, then apply
  // the divide-by-zero and signed-overflow overrides.
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    quot_s = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
    rem_s  = neg_a_q ? (~hi_q + 1'b1) : hi_q;
    case (op_q)
      OP_MUL:                       fix_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV:  fix_res = dz_q ? {XLEN{1'b1}} : (ovf_q ? MIN_V : quot_s);
      OP_DIVU: fix_res = dz_q ? {XLEN{1'b1}} : lo_q;
      OP_REM:  fix_res = dz_q ? a_q : (ovf_q ? {XLEN{1'b0}} : rem_s);
      OP_REMU: fix_res = dz_q ? a_q : hi_q;
      default: fix_res = {XLEN{1'b0}};
    endcase
  end

  // Next-state and datapath-load logic for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    dest_d   = dest_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op_in;
          rd_d    = bus.dest_in;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          dz_d    = (bus.operand_b == '0);
          ovf_d   = (op_in inside {OP_DIV, OP_REM}) && (bus.operand_a == MIN_V) && (&bus.operand_b);
          a_d     = bus.operand_a;
          hi_d    = '0;
          lo_d    = is_div_in ? mag_a : mag_b;
          opnd_d  = is_div_in ? mag_b : mag_a;
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        dest_d   = rd_q;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      dest_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      dest_q   <= dest_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.dest_reg     = dest_q;
  assign bus.reg_write    = (state_q == DONE) && (dest_q != 5'd0);

endmodule
